button_press_detector_multi: RTL and testbench
==============================================

Name: button_press_detector_multi

Overview:
N-channel debounced button-press detector with latched press flags, per-channel acknowledge, and optional auto-repeat while a button is held. Sits between the board push-button inputs and the control FSMs (counter load/enable logic). The control logic consumes each press through a flag/ack handshake. Generalises the single-channel, fixed-depth detector: channel count, debounce depth and repeat timing are parameters.

Parameters:
CHANNELS, 4, number of independent button channels (>=1).
DEBOUNCE_CYCLES, 3, extra consecutive down samples required after the first down sample (>=1).
REPEAT_DELAY, 0, cycles from ack to first auto-repeat while held; 0 disables auto-repeat.
REPEAT_PERIOD, 4, cycles from ack to each later auto-repeat (>=1; used only if REPEAT_DELAY>0).

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
buttonDown  in  CHANNELS  per-channel raw level, 1 = pressed; already synchronised upstream.
ackPress  in  CHANNELS  per-channel acknowledge of wasPressed.
wasPressed  out  CHANNELS  per-channel latched press flag.
isRepeat  out  CHANNELS  qualifies wasPressed: 1 = auto-repeat event, 0 = fresh press.
anyPressed  out  1  OR-reduction of wasPressed.

Behaviour:
- Channels are fully independent; each runs the FSM below. Outputs are decoded from registered state only (no input-to-output combinational path).
- Reset (sampled at a clock edge): every channel goes to WAIT_UP; timers and counters clear; repeat flag clears. After that edge, wasPressed, isRepeat and anyPressed are all 0. A button held through reset is not reported until it is released and pressed again. Reset mid-debounce or mid-hold aborts that activity.
- States per channel: WAIT_UP, BTN_UP, DEBOUNCE, PRESSED, HELD.
- WAIT_UP: buttonDown=0 -> BTN_UP; else stay.
- BTN_UP: buttonDown=1 -> DEBOUNCE with cnt<=1, rpt<=0.
- DEBOUNCE:
  - buttonDown=0 -> BTN_UP.
  - Else if cnt==DEBOUNCE_CYCLES -> PRESSED.
  - Else cnt<=cnt+1.
  - Net effect: DEBOUNCE_CYCLES+1 consecutive down samples. If the first down sample is at edge k, wasPressed rises after edge k+DEBOUNCE_CYCLES. A single up sample restarts debounce.
- PRESSED: wasPressed=1, isRepeat=rpt. Holds until ackPress=1, regardless of buttonDown.
  - On ack with REPEAT_DELAY=0, or with buttonDown=0: -> WAIT_UP.
  - On ack with REPEAT_DELAY>0 and buttonDown=1: -> HELD, timer<=1.
  - A release before ack does not clear the flag.
- HELD: wasPressed=0.
  - buttonDown=0 -> BTN_UP.
  - Else if timer==limit -> PRESSED with rpt<=1.
  - Else timer<=timer+1.
  - limit = REPEAT_DELAY while rpt=0, REPEAT_PERIOD while rpt=1. If ack is at edge a, the repeat flag re-rises after edge a+limit.
- ackPress is ignored in every state except PRESSED. An ack in the same cycle as reset is ignored.
- Widths:
  - cnt is clog2(DEBOUNCE_CYCLES+1) bits.
  - timer is clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits.
  - Neither counter ever wraps: each is reloaded on state entry and bounded by the compare.
- Unused state encodings -> WAIT_UP on the next edge.
- Illegal parameters (DEBOUNCE_CYCLES<1; REPEAT_PERIOD<1 with REPEAT_DELAY>0) are rejected by an elaboration-time check.

Decomposition:
- Shared include (guarded, e.g. button_press_defs.vh): the 3-bit state encodings WAIT_UP, BTN_UP, DEBOUNCE, PRESSED, HELD and a clog2 constant function.
- Sub-module button_press_channel: one channel's FSM, cnt, timer and rpt, carrying the same parameters.
- Top level: generate loop over CHANNELS, plus the anyPressed reduction.

Test Plan (CHANNELS=2, DEBOUNCE_CYCLES=3, REPEAT_DELAY=8, REPEAT_PERIOD=4 unless stated):
1. Clean press: buttonDown[0]=1 from edge 10, ack low -> wasPressed[0]=1 after edge 13 and stays 1 through release. ackPress[0] at edge 20 -> 0 after edge 20; isRepeat[0]=0 throughout.
2. Bounce: down 2 cycles, up 1, down 3, up 1 -> wasPressed never rises. Then down 4 stable samples -> rises after the 4th.
3. Auto-repeat: hold down; ack each assertion one cycle after it rises. First repeat 8 cycles after the first ack, then every 4 cycles after each ack, with isRepeat=1. Release -> no further events; the next fresh press has isRepeat=0.
4. REPEAT_DELAY=0 build: hold 100 cycles and ack -> exactly one pulse. Release then press again -> a second pulse.
5. Reset: 1-cycle reset while a channel is in HELD with the button down -> all outputs 0 after that edge. No event while still held; release, press and 4 samples -> event.
6. Independence: presses on ch0 and ch1 overlapping; ack ch1 only -> ch0 flag unaffected. anyPressed=1 until both are acked. An ack with no pending flag has no effect.

Source files
------------

// File: rtl/button_press_detector_multi_pkg.sv
// Shared definitions for the multi-channel button press detector.
//   state_e       : per-channel FSM state encoding (3 bits, 5 legal values)
//   clog2_f       : constant ceil(log2(v)), minimum result 1
//   max_f         : constant max of two integers
package button_press_detector_multi_pkg;

  typedef enum logic [2:0] {
    WAIT_UP  = 3'd0,
    BTN_UP   = 3'd1,
    DEBOUNCE = 3'd2,
    PRESSED  = 3'd3,
    HELD     = 3'd4
  } state_e;

  // Bit width needed to hold values 0..v-1; never returns less than 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      return 1;
    end else begin
      return r;
    end
  endfunction

  function automatic int max_f(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_press_detector_multi_channel.sv
// One channel of the button press detector: debounce, latched press flag
// with acknowledge, and optional auto-repeat while the button is held.
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   buttonDown : raw (already synchronised) button level, 1 = pressed
//   ackPress   : acknowledge of wasPressed, only honoured while flagged
//   wasPressed : latched press flag (registered)
//   isRepeat   : 1 = flag is an auto-repeat event, 0 = fresh press (registered)
module button_press_detector_multi_channel
  import button_press_detector_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonDown,
  input  logic ackPress,
  output logic wasPressed,
  output logic isRepeat
);

  localparam int CNT_W = clog2_f(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = clog2_f(max_f(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] LIM_FIRST = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] LIM_NEXT  = TMR_W'(REPEAT_PERIOD);
  localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

  if ((DEBOUNCE_CYCLES < 1) || ((REPEAT_DELAY > 0) && (REPEAT_PERIOD < 1))) begin : g_bad_params
    $error("button_press_detector_multi_channel: illegal parameter combination");
  end

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_next_s;
  logic [TMR_W-1:0] limit_s;
  logic             rpt_r;
  logic             rpt_next_s;
  logic             was_pressed_r;
  logic             is_repeat_r;

  // Next-state, counter and repeat-flag logic for the channel FSM.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    timer_next_s = timer_r;
    rpt_next_s   = rpt_r;
    // First repeat waits the longer delay; later ones use the period.
    if (rpt_r) begin
      limit_s = LIM_NEXT;
    end else begin
      limit_s = LIM_FIRST;
    end
    case (state_r)
      WAIT_UP: begin
        // A button held through reset/ack must be seen released first.
        if (!buttonDown) begin
          state_next_s = BTN_UP;
        end else begin
          state_next_s = WAIT_UP;
        end
      end
      BTN_UP: begin
        if (buttonDown) begin
          state_next_s = DEBOUNCE;
          cnt_next_s   = CNT_W'(1);
          rpt_next_s   = 1'b0;
        end else begin
          state_next_s = BTN_UP;
        end
      end
      DEBOUNCE: begin
        if (!buttonDown) begin
          state_next_s = BTN_UP;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = PRESSED;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (ackPress) begin
          if (REPEAT_EN && buttonDown) begin
            state_next_s = HELD;
            timer_next_s = TMR_W'(1);
          end else begin
            state_next_s = WAIT_UP;
          end
        end else begin
          state_next_s = PRESSED;
        end
      end
      HELD: begin
        if (!buttonDown) begin
          state_next_s = BTN_UP;
        end else if (timer_r == limit_s) begin
          state_next_s = PRESSED;
          rpt_next_s   = 1'b1;
        end else begin
          timer_next_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        state_next_s = WAIT_UP;
      end
    endcase
  end

  // State, counters and registered output flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= WAIT_UP;
      cnt_r         <= '0;
      timer_r       <= '0;
      rpt_r         <= 1'b0;
      was_pressed_r <= 1'b0;
      is_repeat_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      timer_r       <= timer_next_s;
      rpt_r         <= rpt_next_s;
      // Outputs are registered copies of the decode of the next state.
      was_pressed_r <= (state_next_s == PRESSED);
      is_repeat_r   <= (state_next_s == PRESSED) && rpt_next_s;
    end
  end

  assign wasPressed = was_pressed_r;
  assign isRepeat   = is_repeat_r;

endmodule

// File: rtl/button_press_detector_multi.sv
// N-channel debounced button press detector with per-channel flag/ack
// handshake and optional auto-repeat.
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   buttonDown : per-channel raw button level, 1 = pressed
//   ackPress   : per-channel acknowledge of wasPressed
//   wasPressed : per-channel latched press flag
//   isRepeat   : per-channel auto-repeat qualifier for wasPressed
//   anyPressed : OR of all wasPressed bits
module button_press_detector_multi
  import button_press_detector_multi_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttonDown,
  input  logic [CHANNELS-1:0] ackPress,
  output logic [CHANNELS-1:0] wasPressed,
  output logic [CHANNELS-1:0] isRepeat,
  output logic                anyPressed
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("button_press_detector_multi: CHANNELS must be at least 1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    button_press_detector_multi_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .buttonDown (buttonDown[g]),
      .ackPress   (ackPress[g]),
      .wasPressed (wasPressed[g]),
      .isRepeat   (isRepeat[g])
    );
  end

  // Every channel flag is a register, so this reduction has no input path.
  assign anyPressed = |wasPressed;

endmodule

// File: tb/tb_button_press_detector_multi.sv
module tb_button_press_detector_multi;

  localparam int DC   = 3;
  localparam int RD_A = 8;
  localparam int RD_B = 0;
  localparam int RP   = 4;

  logic       clock;
  logic       reset;
  logic [1:0] buttonDown;
  logic [1:0] ackPress;
  logic [1:0] was_a, rep_a, was_b, rep_b;
  logic       any_a, any_b;

  int n_cmp;
  int n_mis;

  // Reference model state, indexed [dut][channel]; dut 0 repeats, dut 1 does not.
  bit m_armed [2][2];
  int m_run   [2][2];
  bit m_flag  [2][2];
  bit m_rep   [2][2];
  bit m_hold  [2][2];
  int m_since [2][2];
  int m_limit [2][2];
  int rd      [2];

  button_press_detector_multi #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clock(clock), .reset(reset), .buttonDown(buttonDown), .ackPress(ackPress),
    .wasPressed(was_a), .isRepeat(rep_a), .anyPressed(any_a)
  );

  button_press_detector_multi #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clock(clock), .reset(reset), .buttonDown(buttonDown), .ackPress(ackPress),
    .wasPressed(was_b), .isRepeat(rep_b), .anyPressed(any_b)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behaviour from the rules: a press needs an up sample after disarming,
  // then DC+1 consecutive down samples; held buttons repeat after limit cycles.
  task automatic model_step(input logic [1:0] b, input logic [1:0] a, input logic r);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          m_armed[d][c] = 0; m_run[d][c] = 0; m_flag[d][c] = 0;
          m_rep[d][c] = 0;   m_hold[d][c] = 0;
        end else if (m_flag[d][c]) begin
          if (a[c]) begin
            m_flag[d][c] = 0;
            if (rd[d] > 0 && b[c]) begin
              m_hold[d][c]  = 1;
              m_since[d][c] = 0;
              m_limit[d][c] = m_rep[d][c] ? RP : rd[d];
            end else begin
              m_armed[d][c] = 0;
            end
          end
        end else if (m_hold[d][c]) begin
          if (!b[c]) begin
            m_hold[d][c] = 0; m_armed[d][c] = 1; m_run[d][c] = 0;
          end else begin
            m_since[d][c]++;
            if (m_since[d][c] == m_limit[d][c]) begin
              m_flag[d][c] = 1; m_rep[d][c] = 1; m_hold[d][c] = 0;
            end
          end
        end else if (!m_armed[d][c]) begin
          if (!b[c]) begin
            m_armed[d][c] = 1; m_run[d][c] = 0;
          end
        end else if (b[c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == DC + 1) begin
            m_flag[d][c] = 1; m_rep[d][c] = 0; m_armed[d][c] = 0; m_run[d][c] = 0;
          end
        end else begin
          m_run[d][c] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [1:0] ew [2];
    logic [1:0] er [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        ew[d][c] = m_flag[d][c];
        er[d][c] = m_flag[d][c] & m_rep[d][c];
      end
    end
    cmp("was_a", 32'(was_a), 32'(ew[0]));
    cmp("rep_a", 32'(rep_a), 32'(er[0]));
    cmp("any_a", 32'(any_a), 32'(|ew[0]));
    cmp("was_b", 32'(was_b), 32'(ew[1]));
    cmp("rep_b", 32'(rep_b), 32'(er[1]));
    cmp("any_b", 32'(any_b), 32'(|ew[1]));
  endtask

  task automatic tick(input logic [1:0] b, input logic [1:0] a, input logic r);
    buttonDown = b;
    ackPress   = a;
    reset      = r;
    @(posedge clock);
    model_step(b, a, r);
    #1;
    check_model();
  endtask

  // Clear any pending flags with the buttons released.
  task automatic settle();
    tick(2'b00, 2'b11, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [1:0] rb;
    logic [1:0] ra;
    logic       rr;
    clock = 1'b0; reset = 1'b0; buttonDown = 2'b00; ackPress = 2'b00;
    n_cmp = 0; n_mis = 0;
    rd[0] = RD_A; rd[1] = RD_B;

    // Reset state.
    tick(2'b00, 2'b00, 1'b1);
    cmp("reset_was_a", 32'(was_a), 32'd0);
    cmp("reset_any_b", 32'(any_b), 32'd0);
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);

    // 1. Clean press on ch0, flag survives release until ack.
    for (int i = 0; i < 3; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t1_before_4th", 32'(was_a[0]), 32'd0);
    tick(2'b01, 2'b00, 1'b0);
    cmp("t1_rise", 32'(was_a[0]), 32'd1);
    cmp("t1_fresh", 32'(rep_a[0]), 32'd0);
    tick(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) tick(2'b00, 2'b00, 1'b0);
    cmp("t1_after_release", 32'(was_a[0]), 32'd1);
    tick(2'b00, 2'b01, 1'b0);
    cmp("t1_acked", 32'(was_a[0]), 32'd0);
    settle();

    // 2. Bounce never qualifies, then a stable run of DC+1 does.
    pulses = 0;
    tick(2'b01, 2'b00, 1'b0); pulses += was_a[0];
    tick(2'b01, 2'b00, 1'b0); pulses += was_a[0];
    tick(2'b00, 2'b00, 1'b0); pulses += was_a[0];
    for (int i = 0; i < 3; i++) begin tick(2'b01, 2'b00, 1'b0); pulses += was_a[0]; end
    tick(2'b00, 2'b00, 1'b0); pulses += was_a[0];
    cmp("t2_bounce_no_event", 32'(pulses), 32'd0);
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t2_stable_rise", 32'(was_a[0]), 32'd1);
    settle();

    // 3. Auto-repeat timing while held, ack one cycle after each rise.
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b01, 1'b0);
    n = 0;
    do begin tick(2'b01, 2'b00, 1'b0); n++; end while (!was_a[0] && n < 40);
    cmp("t3_first_repeat_gap", 32'(n), 32'd8);
    cmp("t3_first_is_repeat", 32'(rep_a[0]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick(2'b01, 2'b00, 1'b0);
      tick(2'b01, 2'b01, 1'b0);
      n = 0;
      do begin tick(2'b01, 2'b00, 1'b0); n++; end while (!was_a[0] && n < 40);
      cmp("t3_period_gap", 32'(n), 32'd4);
      cmp("t3_period_is_repeat", 32'(rep_a[0]), 32'd1);
    end
    tick(2'b00, 2'b01, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin tick(2'b00, 2'b00, 1'b0); pulses += was_a[0]; end
    cmp("t3_no_event_after_release", 32'(pulses), 32'd0);
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t3_fresh_press", 32'(was_a[0]), 32'd1);
    cmp("t3_fresh_not_repeat", 32'(rep_a[0]), 32'd0);
    settle();

    // 4. Non-repeating build: one pulse per press however long it is held.
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t4_first_pulse", 32'(was_b[0]), 32'd1);
    tick(2'b01, 2'b01, 1'b0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(2'b01, 2'b00, 1'b0);
      pulses += was_b[0];
      if (was_a[0]) tick(2'b01, 2'b01, 1'b0);
    end
    cmp("t4_no_repeat_while_held", 32'(pulses), 32'd0);
    tick(2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t4_second_pulse", 32'(was_b[0]), 32'd1);
    settle();

    // 5. Reset during hold, with an ack in the same cycle.
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b01, 1'b1);
    cmp("t5_reset_was", 32'(was_a), 32'd0);
    cmp("t5_reset_any", 32'(any_a), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(2'b01, 2'b00, 1'b0); pulses += was_a[0]; end
    cmp("t5_held_through_reset", 32'(pulses), 32'd0);
    tick(2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) tick(2'b01, 2'b00, 1'b0);
    cmp("t5_event_after_repress", 32'(was_a[0]), 32'd1);
    settle();

    // 6. Channel independence and stray acks.
    tick(2'b00, 2'b11, 1'b0);
    tick(2'b01, 2'b00, 1'b0);
    tick(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) tick(2'b11, 2'b00, 1'b0);
    cmp("t6_both_flagged", 32'(was_a), 32'd3);
    tick(2'b00, 2'b10, 1'b0);
    cmp("t6_ch0_kept", 32'(was_a), 32'd1);
    cmp("t6_any_still", 32'(any_a), 32'd1);
    tick(2'b00, 2'b10, 1'b0);
    cmp("t6_stray_ack", 32'(was_a), 32'd1);
    tick(2'b00, 2'b01, 1'b0);
    cmp("t6_any_clear", 32'(any_a), 32'd0);
    settle();

    // Randomised run against the model.
    rb = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
        ra[c] = ($urandom_range(0, 2) == 0);
      end
      rr = ($urandom_range(0, 149) == 0);
      tick(rb, ra, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
